execute_stage_md: RTL and testbench

- Parametrised next-generation RV32/RV64 execute stage with EX/MEM pipeline register.
- Adds a full RV branch-condition set, JALR target generation, and a 4-bit ALU op space over the older 3-bit stage.
- Adds an M-extension unit: single-cycle multiply and a multi-cycle iterative divider. While the divider runs, the stage stalls upstream and inserts bubbles downstream.
- Sits between the ID/EX register and the memory stage; fed by the hazard unit's forwarding selects.

---
 rtl/execute_stage_md.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_execute_stage_md.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage_md.sv
// Execute stage with M-extension unit and EX/MEM pipeline register.
// Inputs : ID/EX operands and controls, forwarding selects/values, flush_e.
// Outputs: EX/MEM register (*_m), pc_target_e/pc_src_e redirect, stall_ex,
//          rs1_e_h/rs2_e_h passthrough to the hazard unit.
module execute_stage_md #(
  parameter int XLEN      = 32,
  parameter int RA_W      = 5,
  parameter int ENABLE_MD = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_e,
  input  logic [XLEN-1:0] rd1_e,
  input  logic [XLEN-1:0] rd2_e,
  input  logic [XLEN-1:0] pc_e,
  input  logic [XLEN-1:0] pc_plus4_e,
  input  logic [XLEN-1:0] imm_ext_e,
  input  logic            reg_write_e,
  input  logic            alu_src_e,
  input  logic            mem_write_e,
  input  logic            branch_e,
  input  logic            jump_e,
  input  logic            jalr_e,
  input  logic            md_en_e,
  input  logic [1:0]      result_src_e,
  input  logic [3:0]      alu_control_e,
  input  logic [2:0]      funct3_e,
  input  logic [2:0]      md_op_e,
  input  logic [RA_W-1:0] rs1_e,
  input  logic [RA_W-1:0] rs2_e,
  input  logic [RA_W-1:0] rd_e,
  input  logic [1:0]      forward_a_e,
  input  logic [1:0]      forward_b_e,
  input  logic [XLEN-1:0] result_w,
  input  logic [XLEN-1:0] alu_result_fwd,
  output logic [XLEN-1:0] alu_result_m,
  output logic [XLEN-1:0] write_data_m,
  output logic [XLEN-1:0] pc_plus4_m,
  output logic [RA_W-1:0] rd_m,
  output logic            reg_write_m,
  output logic            mem_write_m,
  output logic [1:0]      result_src_m,
  output logic [XLEN-1:0] pc_target_e,
  output logic            pc_src_e,
  output logic            stall_ex,
  output logic [RA_W-1:0] rs1_e_h,
  output logic [RA_W-1:0] rs2_e_h
);

  localparam int SH_W  = $clog2(XLEN);
  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;

  div_state_e div_state_q, div_state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  quo_q, quo_d, rem_q, rem_d, dvsr_q, dvsr_d;
  logic             neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, is_rem_q, is_rem_d;

  logic [XLEN-1:0]  alu_result_m_q, alu_result_m_d, write_data_m_q, write_data_m_d;
  logic [XLEN-1:0]  pc_plus4_m_q, pc_plus4_m_d;
  logic [RA_W-1:0]  rd_m_q, rd_m_d;
  logic             reg_write_m_q, reg_write_m_d, mem_write_m_q, mem_write_m_d;
  logic [1:0]       result_src_m_q, result_src_m_d;

  logic [XLEN-1:0]   src_a, fwd_b, src_b, alu_result, mul_result, div_result;
  logic [SH_W-1:0]   shamt;
  logic              br_cond, div_start, div_signed, div_special;
  logic              a_neg, b_neg;
  logic [2*XLEN-1:0] mul_a_ext, mul_b_ext, mul_prod;
  logic [XLEN:0]     shifted;

  assign rs1_e_h = rs1_e;
  assign rs2_e_h = rs2_e;

  always_comb begin
    case (forward_a_e)
      2'b01:   src_a = result_w;
      2'b10:   src_a = alu_result_fwd;
      default: src_a = rd1_e;
    endcase
    case (forward_b_e)
      2'b01:   fwd_b = result_w;
      2'b10:   fwd_b = alu_result_fwd;
      default: fwd_b = rd2_e;
    endcase
    src_b = alu_src_e ? imm_ext_e : fwd_b;
    shamt = src_b[SH_W-1:0];
  end

  always_comb begin
    case (alu_control_e)
      4'b0000: alu_result = src_a + src_b;
      4'b0001: alu_result = src_a - src_b;
      4'b0010: alu_result = src_a & src_b;
      4'b0011: alu_result = src_a | src_b;
      4'b0100: alu_result = src_a ^ src_b;
      4'b0101: alu_result = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      4'b0110: alu_result = {{(XLEN-1){1'b0}}, src_a < src_b};
      4'b0111: alu_result = src_a << shamt;
      4'b1000: alu_result = src_a >> shamt;
      4'b1001: alu_result = $signed(src_a) >>> shamt;
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    case (funct3_e)
      3'b000:  br_cond = (src_a == fwd_b);
      3'b001:  br_cond = (src_a != fwd_b);
      3'b100:  br_cond = ($signed(src_a) <  $signed(fwd_b));
      3'b101:  br_cond = ($signed(src_a) >= $signed(fwd_b));
      3'b110:  br_cond = (src_a <  fwd_b);
      3'b111:  br_cond = (src_a >= fwd_b);
      default: br_cond = 1'b0;
    endcase
    if (jalr_e) begin
      pc_target_e    = src_a + imm_ext_e;
      pc_target_e[0] = 1'b0;
    end else begin
      pc_target_e = pc_e + imm_ext_e;
    end
    pc_src_e = ((branch_e & br_cond) | jump_e) & ~flush_e;
  end

  // Sign-extend each operand to 2*XLEN according to op so one multiplier
  // serves mul/mulh/mulhsu/mulhu.
  always_comb begin
    mul_a_ext  = {{XLEN{(md_op_e[1:0] != 2'b11) & src_a[XLEN-1]}}, src_a};
    mul_b_ext  = {{XLEN{(md_op_e[1:0] == 2'b01) & src_b[XLEN-1]}}, src_b};
    mul_prod   = mul_a_ext * mul_b_ext;
    mul_result = (md_op_e[1:0] == 2'b00) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    div_start   = (ENABLE_MD != 0) && md_en_e && md_op_e[2] && !flush_e;
    div_signed  = ~md_op_e[0];
    div_special = (src_b == '0) || (div_signed && (src_a == SMIN) && (src_b == '1));
    a_neg       = div_signed & src_a[XLEN-1];
    b_neg       = div_signed & src_b[XLEN-1];
    div_result  = is_rem_q ? (neg_rem_q ? -rem_q : rem_q)
                           : (neg_quo_q ? -quo_q : quo_q);
  end

  // Divider FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) div_state_q <= DIV_IDLE;
    else      div_state_q <= div_state_d;
  end

  // Divider FSM: next state
  always_comb begin
    div_state_d = div_state_q;
    if (flush_e) begin
      div_state_d = DIV_IDLE;
    end else begin
      case (div_state_q)
        DIV_IDLE: if (div_start) div_state_d = div_special ? DIV_DONE : DIV_BUSY;
        DIV_BUSY: if (cnt_q == CNT_W'(1)) div_state_d = DIV_DONE;
        default:  div_state_d = DIV_IDLE;
      endcase
    end
  end

  // Divider FSM: outputs
  always_comb begin
    stall_ex = 1'b0;
    if (rst && !flush_e && (ENABLE_MD != 0)) begin
      case (div_state_q)
        DIV_IDLE: stall_ex = div_start;
        DIV_BUSY: stall_ex = 1'b1;
        default:  stall_ex = 1'b0;
      endcase
    end
  end

  // Special cases preload the final quotient/remainder so DONE needs no extra path.
  always_comb begin
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvsr_d    = dvsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    is_rem_d  = is_rem_q;
    shifted   = {rem_q, quo_q[XLEN-1]};
    if (flush_e) begin
      cnt_d = '0;
    end else if (div_state_q == DIV_IDLE && div_start) begin
      is_rem_d = md_op_e[1];
      dvsr_d   = b_neg ? -src_b : src_b;
      if (div_special) begin
        cnt_d     = '0;
        quo_d     = (src_b == '0) ? '1 : src_a;
        rem_d     = (src_b == '0) ? src_a : '0;
        neg_quo_d = 1'b0;
        neg_rem_d = 1'b0;
      end else begin
        cnt_d     = CNT_W'(XLEN);
        quo_d     = a_neg ? -src_a : src_a;
        rem_d     = '0;
        neg_quo_d = a_neg ^ b_neg;
        neg_rem_d = a_neg;
      end
    end else if (div_state_q == DIV_BUSY) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (shifted >= {1'b0, dvsr_q}) begin
        rem_d = shifted[XLEN-1:0] - dvsr_q;
        quo_d = {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_d = shifted[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvsr_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvsr_q    <= dvsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      is_rem_q  <= is_rem_d;
    end
  end

  always_comb begin
    alu_result_m_d = '0;
    write_data_m_d = '0;
    pc_plus4_m_d   = '0;
    rd_m_d         = '0;
    reg_write_m_d  = 1'b0;
    mem_write_m_d  = 1'b0;
    result_src_m_d = '0;
    if (!flush_e && !stall_ex) begin
      if ((ENABLE_MD != 0) && md_en_e)
        alu_result_m_d = md_op_e[2] ? div_result : mul_result;
      else
        alu_result_m_d = alu_result;
      write_data_m_d = fwd_b;
      pc_plus4_m_d   = pc_plus4_e;
      rd_m_d         = rd_e;
      reg_write_m_d  = reg_write_e;
      mem_write_m_d  = mem_write_e;
      result_src_m_d = result_src_e;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_result_m_q <= '0;
      write_data_m_q <= '0;
      pc_plus4_m_q   <= '0;
      rd_m_q         <= '0;
      reg_write_m_q  <= 1'b0;
      mem_write_m_q  <= 1'b0;
      result_src_m_q <= '0;
    end else begin
      alu_result_m_q <= alu_result_m_d;
      write_data_m_q <= write_data_m_d;
      pc_plus4_m_q   <= pc_plus4_m_d;
      rd_m_q         <= rd_m_d;
      reg_write_m_q  <= reg_write_m_d;
      mem_write_m_q  <= mem_write_m_d;
      result_src_m_q <= result_src_m_d;
    end
  end

  assign alu_result_m = alu_result_m_q;
  assign write_data_m = write_data_m_q;
  assign pc_plus4_m   = pc_plus4_m_q;
  assign rd_m         = rd_m_q;
  assign reg_write_m  = reg_write_m_q;
  assign mem_write_m  = mem_write_m_q;
  assign result_src_m = result_src_m_q;

endmodule

// File: tb/tb_execute_stage_md.sv
module tb_execute_stage_md;
  localparam int XLEN = 32;
  localparam int RA_W = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush_e;
  logic [XLEN-1:0] rd1_e, rd2_e, pc_e, pc_plus4_e, imm_ext_e;
  logic            reg_write_e, alu_src_e, mem_write_e, branch_e, jump_e, jalr_e, md_en_e;
  logic [1:0]      result_src_e;
  logic [3:0]      alu_control_e;
  logic [2:0]      funct3_e, md_op_e;
  logic [RA_W-1:0] rs1_e, rs2_e, rd_e;
  logic [1:0]      forward_a_e, forward_b_e;
  logic [XLEN-1:0] result_w, alu_result_fwd;
  logic [XLEN-1:0] alu_result_m, write_data_m, pc_plus4_m, pc_target_e;
  logic [RA_W-1:0] rd_m, rs1_e_h, rs2_e_h;
  logic            reg_write_m, mem_write_m, pc_src_e, stall_ex;
  logic [1:0]      result_src_m;

  execute_stage_md #(.XLEN(XLEN), .RA_W(RA_W), .ENABLE_MD(1)) dut (
    .clk(clk), .rst(rst), .flush_e(flush_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .pc_e(pc_e), .pc_plus4_e(pc_plus4_e), .imm_ext_e(imm_ext_e),
    .reg_write_e(reg_write_e), .alu_src_e(alu_src_e), .mem_write_e(mem_write_e),
    .branch_e(branch_e), .jump_e(jump_e), .jalr_e(jalr_e), .md_en_e(md_en_e),
    .result_src_e(result_src_e), .alu_control_e(alu_control_e), .funct3_e(funct3_e),
    .md_op_e(md_op_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .result_w(result_w), .alu_result_fwd(alu_result_fwd),
    .alu_result_m(alu_result_m), .write_data_m(write_data_m), .pc_plus4_m(pc_plus4_m),
    .rd_m(rd_m), .reg_write_m(reg_write_m), .mem_write_m(mem_write_m),
    .result_src_m(result_src_m), .pc_target_e(pc_target_e), .pc_src_e(pc_src_e),
    .stall_ex(stall_ex), .rs1_e_h(rs1_e_h), .rs2_e_h(rs2_e_h)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] res;
    logic            rw;
    string           tag;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    flush_e = 0; rd1_e = '0; rd2_e = '0; pc_e = '0; pc_plus4_e = '0; imm_ext_e = '0;
    reg_write_e = 0; alu_src_e = 0; mem_write_e = 0; branch_e = 0; jump_e = 0;
    jalr_e = 0; md_en_e = 0; result_src_e = '0; alu_control_e = '0; funct3_e = '0;
    md_op_e = '0; rs1_e = '0; rs2_e = '0; rd_e = '0; forward_a_e = '0; forward_b_e = '0;
    result_w = '0; alu_result_fwd = '0;
  endtask

  // Inputs already driven (at a negedge); expectation queued, checked after capture edge.
  task automatic issue(input string tag, input logic [XLEN-1:0] res);
    exp_t e;
    e.res = res; e.rw = reg_write_e; e.tag = tag;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk({e.tag, "_res"}, alu_result_m, e.res);
    chk({e.tag, "_rw"}, reg_write_m, e.rw);
    @(negedge clk);
  endtask

  task automatic div_test(input string tag, input logic [2:0] op, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [XLEN-1:0] res, input int stall_exp);
    exp_t e;
    int   n;
    md_en_e = 1; md_op_e = op; rd1_e = a; rd2_e = b; alu_src_e = 0;
    forward_a_e = 2'b00; forward_b_e = 2'b00; reg_write_e = 1; alu_control_e = 4'b0000;
    e.res = res; e.rw = 1'b1; e.tag = tag;
    sb.push_back(e);
    #1;
    n = 0;
    while (stall_ex === 1'b1 && n < 200) begin
      n++;
      @(negedge clk); #1;
      if (n == 1) chk({tag, "_bubble_rw"}, reg_write_m, 1'b0);
    end
    chk({tag, "_stall_cycles"}, n, stall_exp);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk({e.tag, "_res"}, alu_result_m, e.res);
    chk({e.tag, "_rw"}, reg_write_m, e.rw);
    md_en_e = 0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst = 0;
    #12;
    chk("reset_alu_result", alu_result_m, 0);
    chk("reset_reg_write", reg_write_m, 0);
    chk("reset_stall", stall_ex, 0);
    @(negedge clk);
    rst = 1;

    // add with forwarding from alu_result_fwd and immediate operand
    rd1_e = 5; forward_a_e = 2'b10; alu_result_fwd = 7; imm_ext_e = 3; alu_src_e = 1;
    alu_control_e = 4'b0000; reg_write_e = 1; rd2_e = 32'h55; pc_plus4_e = 32'h104;
    rd_e = 7; result_src_e = 2'b01; mem_write_e = 1; rs1_e = 3; rs2_e = 9;
    #1;
    chk("rs1_passthrough", rs1_e_h, 3);
    chk("rs2_passthrough", rs2_e_h, 9);
    issue("add_fwd", 32'd10);
    chk("write_data", write_data_m, 32'h55);
    chk("pc_plus4_m", pc_plus4_m, 32'h104);
    chk("rd_m", rd_m, 7);
    chk("result_src_m", result_src_m, 2'b01);
    chk("mem_write_m", mem_write_m, 1);

    // sub: A from result_w, B select 11 behaves as regfile
    clear_inputs();
    forward_a_e = 2'b01; result_w = 20; rd1_e = 99; forward_b_e = 2'b11; rd2_e = 3;
    alu_control_e = 4'b0001; reg_write_e = 0;
    issue("sub_fwd11", 32'd17);
    chk("write_data_fwd11", write_data_m, 32'd3);

    clear_inputs(); reg_write_e = 1;
    rd1_e = 32'h8000_0000; imm_ext_e = 32'h24; alu_src_e = 1; alu_control_e = 4'b1001;
    issue("sra", 32'hF800_0000);
    alu_control_e = 4'b1000;
    issue("srl", 32'h0800_0000);
    clear_inputs(); reg_write_e = 1;
    rd1_e = 32'hFFFF_FFFF; rd2_e = 1; alu_control_e = 4'b0101;
    issue("slt", 32'd1);
    alu_control_e = 4'b0110;
    issue("sltu", 32'd0);
    alu_control_e = 4'b1111;
    issue("undef_op", 32'd0);

    // branches and jumps (combinational)
    clear_inputs();
    rd1_e = 32'hFFFF_FFFF; rd2_e = 1; funct3_e = 3'b101; branch_e = 1;
    pc_e = 32'h100; imm_ext_e = 32'h20;
    #1; chk("bge_not_taken", pc_src_e, 0);
    funct3_e = 3'b111;
    #1; chk("bgeu_taken", pc_src_e, 1);
    chk("bgeu_target", pc_target_e, 32'h120);
    funct3_e = 3'b010;
    #1; chk("f3_010_never", pc_src_e, 0);
    funct3_e = 3'b111; flush_e = 1;
    #1; chk("flush_kills_redirect", pc_src_e, 0);
    clear_inputs();
    rd1_e = 32'h1001; imm_ext_e = 4; jalr_e = 1; jump_e = 1; pc_e = 32'h500;
    #1; chk("jalr_target", pc_target_e, 32'h1004);
    chk("jalr_redirect", pc_src_e, 1);
    @(negedge clk);

    // multiply, single cycle
    clear_inputs(); reg_write_e = 1; md_en_e = 1;
    rd1_e = 32'h8000_0000; rd2_e = 2; md_op_e = 3'b001;
    #1; chk("mul_no_stall", stall_ex, 0);
    issue("mulh", 32'hFFFF_FFFF);
    md_op_e = 3'b011;
    issue("mulhu", 32'h0000_0001);
    rd1_e = 32'hFFFF_FFFF; md_op_e = 3'b010;
    issue("mulhsu", 32'hFFFF_FFFF);
    rd1_e = 7; rd2_e = 6; md_op_e = 3'b000;
    issue("mul", 32'd42);
    clear_inputs();

    // divides
    div_test("divu", 3'b101, 32'd100, 32'd7, 32'd14, 33);
    div_test("remu", 3'b111, 32'd100, 32'd7, 32'd2, 33);
    div_test("div_neg", 3'b100, -32'sd7, 32'd2, -32'sd3, 33);
    div_test("rem_neg", 3'b110, -32'sd7, 32'd2, -32'sd1, 33);
    div_test("div_by0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    div_test("remu_by0", 3'b111, 32'd5, 32'd0, 32'd5, 1);
    div_test("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);

    // flush on cycle 10 of a divide
    clear_inputs();
    md_en_e = 1; md_op_e = 3'b101; rd1_e = 100; rd2_e = 7; reg_write_e = 1;
    for (int i = 1; i < 10; i++) @(negedge clk);
    #1; chk("flush_pre_stall", stall_ex, 1);
    flush_e = 1;
    #1; chk("flush_stall_drop", stall_ex, 0);
    @(posedge clk); #1;
    chk("flush_bubble_rw", reg_write_m, 0);
    chk("flush_bubble_res", alu_result_m, 0);
    @(negedge clk);
    flush_e = 0;
    div_test("divu_after_flush", 3'b101, 32'd100, 32'd7, 32'd14, 33);

    // reset in the middle of a divide
    clear_inputs();
    md_en_e = 1; md_op_e = 3'b100; rd1_e = -32'sd7; rd2_e = 2; reg_write_e = 1;
    repeat (5) @(negedge clk);
    #1; rst = 0;
    #1;
    chk("rst_mid_stall", stall_ex, 0);
    chk("rst_mid_rw", reg_write_m, 0);
    chk("rst_mid_res", alu_result_m, 0);
    @(negedge clk);
    rst = 1;
    div_test("div_after_rst", 3'b100, -32'sd7, 32'd2, -32'sd3, 33);

    // async reset clears a live EX/MEM value
    clear_inputs();
    rd1_e = 32'h1234; rd2_e = 32'h10; alu_control_e = 4'b0011; reg_write_e = 1;
    pc_plus4_e = 32'h44;
    issue("or", 32'h1234);
    #2; rst = 0;
    #1;
    chk("rst_async_res", alu_result_m, 0);
    chk("rst_async_rw", reg_write_m, 0);
    chk("rst_async_pc4", pc_plus4_m, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
